// File: rtl/datapath_sequencer_if.sv
// Fetch-to-sequencer instruction handshake: one 32-bit LEGv8 word per valid/ready transfer.
interface datapath_sequencer_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/datapath_sequencer.sv
// Multi-cycle LEGv8 control sequencer: done 2 cycles after accept (loads LOAD_CYCLES+1); accepts only in IDLE.
// Optional flag register built when DPSEQ_FLAGREG_EN is defined, otherwise flags_q is tied low.
module datapath_sequencer #(
  parameter int LOAD_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  datapath_sequencer_if.slave  fetch,
  input  logic [3:0]           flags,
  output logic [4:0]           Rd,
  output logic [4:0]           Rm,
  output logic [4:0]           Rn,
  output logic [8:0]           Daddr9,
  output logic [11:0]          Imm12,
  output logic [1:0]           Shamt,
  output logic [15:0]          Imm16,
  output logic                 Reg2Loc,
  output logic                 ALUSrc,
  output logic                 MemToReg,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 MemRead,
  output logic                 ChooseImm,
  output logic                 xferByte,
  output logic                 ChooseMovk,
  output logic                 ChooseMovz,
  output logic [2:0]           ALUOp,
  output logic [3:0]           flags_q,
  output logic                 done,
  output logic                 illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, MEM, DONE} state_t;
  typedef enum logic [3:0] {
    OP_ILL, OP_ADDI, OP_ADDS, OP_SUBS, OP_STUR, OP_STURB,
    OP_LDUR, OP_LDURB, OP_MOVK, OP_MOVZ
  } op_t;

  localparam logic [1:0] MEM_LAST = 2'(LOAD_CYCLES - 2);

  function automatic op_t decode(input logic [31:0] w);
    op_t op;
    op = OP_ILL;
    if (w[31:22] == 10'b1001000100)     op = OP_ADDI;
    else if (w[31:23] == 9'b111100101)  op = OP_MOVK;
    else if (w[31:23] == 9'b110100101)  op = OP_MOVZ;
    else begin
      case (w[31:21])
        11'b10101011000: op = OP_ADDS;
        11'b11101011000: op = OP_SUBS;
        11'b11111000000: op = OP_STUR;
        11'b00111000000: op = OP_STURB;
        11'b11111000010: op = OP_LDUR;
        11'b00111000010: op = OP_LDURB;
        default:         op = OP_ILL;
      endcase
    end
    return op;
  endfunction

  state_t      state, state_n;
  op_t         op_q, dec_in;
  logic [31:0] ir;
  logic [1:0]  cnt;
  logic        illegal_q;
  logic        ready, accept;
  logic        is_load, is_store, is_byte;

  assign ready             = (state == IDLE);
  assign fetch.instr_ready = ready;
  assign accept            = fetch.instr_valid & ready;
  assign dec_in            = decode(fetch.instr);

  assign is_load  = (op_q == OP_LDUR) || (op_q == OP_LDURB);
  assign is_store = (op_q == OP_STUR) || (op_q == OP_STURB);
  assign is_byte  = (op_q == OP_STURB) || (op_q == OP_LDURB);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op_q      <= OP_ILL;
      ir        <= '0;
      cnt       <= '0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_n;
      illegal_q <= 1'b0;
      if (accept) begin
        ir        <= fetch.instr;
        op_q      <= dec_in;
        illegal_q <= (dec_in == OP_ILL);
      end
      if (state == EXEC)     cnt <= '0;
      else if (state == MEM) cnt <= cnt + 2'd1;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept && dec_in != OP_ILL) state_n = EXEC;
      EXEC:    state_n = is_load ? MEM : DONE;
      MEM:     if (cnt == MEM_LAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Controls are only ever non-zero in EXEC and MEM.
  always_comb begin
    Reg2Loc    = 1'b0;
    ALUSrc     = 1'b0;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    MemRead    = 1'b0;
    ChooseImm  = 1'b0;
    xferByte   = 1'b0;
    ChooseMovk = 1'b0;
    ChooseMovz = 1'b0;
    ALUOp      = 3'b000;
    case (state)
      EXEC: begin
        Reg2Loc = !is_store;
        case (op_q)
          OP_ADDI: begin
            ChooseImm = 1'b1;
            ALUSrc    = 1'b1;
            ALUOp     = 3'b010;
            RegWrite  = 1'b1;
          end
          OP_ADDS: begin
            ALUOp    = 3'b010;
            RegWrite = 1'b1;
          end
          OP_SUBS: begin
            ALUOp    = 3'b011;
            RegWrite = 1'b1;
          end
          OP_STUR, OP_STURB: begin
            ALUSrc   = 1'b1;
            ALUOp    = 3'b010;
            MemWrite = 1'b1;
            xferByte = is_byte;
          end
          OP_LDUR, OP_LDURB: begin
            ALUSrc   = 1'b1;
            MemToReg = 1'b1;
            MemRead  = 1'b1;
            ALUOp    = 3'b010;
            xferByte = is_byte;
          end
          OP_MOVK: begin
            ChooseMovk = 1'b1;
            RegWrite   = 1'b1;
          end
          OP_MOVZ: begin
            ChooseMovz = 1'b1;
            RegWrite   = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        Reg2Loc  = 1'b1;
        ALUSrc   = 1'b1;
        MemToReg = 1'b1;
        MemRead  = 1'b1;
        ALUOp    = 3'b010;
        xferByte = is_byte;
        RegWrite = (cnt == MEM_LAST);
      end
      default: ;
    endcase
  end

  assign done    = (state == DONE);
  assign illegal = illegal_q;

  assign Rd     = ir[4:0];
  assign Rn     = ir[9:5];
  assign Rm     = ir[20:16];
  assign Daddr9 = ir[20:12];
  assign Imm12  = ir[21:10];
  assign Imm16  = ir[20:5];
  assign Shamt  = ir[22:21];

`ifdef DPSEQ_FLAGREG_EN
  logic [3:0] flags_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      flags_r <= '0;
    else if (state == EXEC && (op_q == OP_ADDS || op_q == OP_SUBS))
      flags_r <= flags;
  end

  assign flags_q = flags_r;
`else
  logic unused_flags;
  assign unused_flags = ^flags;
  assign flags_q      = 4'b0000;
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer (LOAD_CYCLES=3); checks at negedge, drives at negedge.
module tb_datapath_sequencer;

`ifdef DPSEQ_FLAGREG_EN
  localparam logic [3:0] SUBS_FLAGS = 4'b1000;
`else
  localparam logic [3:0] SUBS_FLAGS = 4'b0000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  flags;
  logic [4:0]  Rd, Rm, Rn;
  logic [8:0]  Daddr9;
  logic [11:0] Imm12;
  logic [1:0]  Shamt;
  logic [15:0] Imm16;
  logic        Reg2Loc, ALUSrc, MemToReg, RegWrite, MemWrite, MemRead;
  logic        ChooseImm, xferByte, ChooseMovk, ChooseMovz;
  logic [2:0]  ALUOp;
  logic [3:0]  flags_q;
  logic        done, illegal;

  int checks = 0;
  int errors = 0;

  datapath_sequencer_if fetch_if ();

  datapath_sequencer #(.LOAD_CYCLES(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch      (fetch_if),
    .flags      (flags),
    .Rd         (Rd),
    .Rm         (Rm),
    .Rn         (Rn),
    .Daddr9     (Daddr9),
    .Imm12      (Imm12),
    .Shamt      (Shamt),
    .Imm16      (Imm16),
    .Reg2Loc    (Reg2Loc),
    .ALUSrc     (ALUSrc),
    .MemToReg   (MemToReg),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .ChooseImm  (ChooseImm),
    .xferByte   (xferByte),
    .ChooseMovk (ChooseMovk),
    .ChooseMovz (ChooseMovz),
    .ALUOp      (ALUOp),
    .flags_q    (flags_q),
    .done       (done),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset                = 1'b0;
    flags                = 4'b0000;
    fetch_if.instr_valid = 1'b0;
    fetch_if.instr       = 32'h0;
    repeat (2) @(negedge clk);

    chk("rst_ready", fetch_if.instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_reg2loc", Reg2Loc, 0);
    chk("rst_flags_q", flags_q, 0);
    chk("rst_rd", Rd, 0);
    reset = 1'b1;
    @(negedge clk);

    // ADDI X0,X31,#512; flags driven in EXEC must not be latched
    fetch_if.instr       = 32'h910803E0;
    fetch_if.instr_valid = 1'b1;
    flags                = 4'b0110;
    @(negedge clk);
    fetch_if.instr_valid = 1'b0;
    fetch_if.instr       = 32'hFFFFFFFF;
    chk("addi_ready", fetch_if.instr_ready, 0);
    chk("addi_chooseimm", ChooseImm, 1);
    chk("addi_alusrc", ALUSrc, 1);
    chk("addi_regwrite", RegWrite, 1);
    chk("addi_aluop", ALUOp, 3'b010);
    chk("addi_reg2loc", Reg2Loc, 1);
    chk("addi_rd", Rd, 0);
    chk("addi_rn", Rn, 31);
    chk("addi_imm12", Imm12, 512);
    chk("addi_done_early", done, 0);
    @(negedge clk);
    chk("addi_done", done, 1);
    chk("addi_done_regwrite", RegWrite, 0);
    chk("addi_done_chooseimm", ChooseImm, 0);
    chk("addi_flags_q", flags_q, 0);
    @(negedge clk);
    chk("addi_idle_ready", fetch_if.instr_ready, 1);
    chk("addi_idle_done", done, 0);

    // MOVK X0,#0xFFFF,LSL 16 with valid held high while busy
    fetch_if.instr       = 32'hF2BFFFE0;
    fetch_if.instr_valid = 1'b1;
    @(negedge clk);
    chk("movk_choosemovk", ChooseMovk, 1);
    chk("movk_shamt", Shamt, 2'b01);
    chk("movk_imm16", Imm16, 16'hFFFF);
    chk("movk_aluop", ALUOp, 3'b000);
    chk("movk_regwrite", RegWrite, 1);
    chk("movk_ready", fetch_if.instr_ready, 0);
    @(negedge clk);
    chk("movk_done", done, 1);
    chk("movk_done_regwrite", RegWrite, 0);
    chk("movk_done_choosemovk", ChooseMovk, 0);
    fetch_if.instr_valid = 1'b0;
    @(negedge clk);
    chk("movk_hold_ready", fetch_if.instr_ready, 1);
    chk("movk_hold_regwrite", RegWrite, 0);
    chk("movk_hold_choosemovk", ChooseMovk, 0);

    // SUBS X5,X31,X30 with flags 1000 in EXEC
    fetch_if.instr       = 32'hEB1E03E5;
    fetch_if.instr_valid = 1'b1;
    flags                = 4'b0000;
    @(negedge clk);
    fetch_if.instr_valid = 1'b0;
    flags                = 4'b1000;
    chk("subs_aluop", ALUOp, 3'b011);
    chk("subs_regwrite", RegWrite, 1);
    chk("subs_rd", Rd, 5);
    chk("subs_rn", Rn, 31);
    chk("subs_rm", Rm, 30);
    @(negedge clk);
    flags = 4'b0001;
    chk("subs_done", done, 1);
    chk("subs_flags_q", flags_q, SUBS_FLAGS);
    @(negedge clk);
    chk("subs_flags_q_hold", flags_q, SUBS_FLAGS);

    // LDURB X9,[X31,#16] with three load cycles
    fetch_if.instr       = 32'h384103E9;
    fetch_if.instr_valid = 1'b1;
    @(negedge clk);
    fetch_if.instr_valid = 1'b0;
    chk("ldurb_exec_memread", MemRead, 1);
    chk("ldurb_exec_regwrite", RegWrite, 0);
    chk("ldurb_exec_xferbyte", xferByte, 1);
    chk("ldurb_exec_memtoreg", MemToReg, 1);
    chk("ldurb_daddr9", Daddr9, 16);
    chk("ldurb_rd", Rd, 9);
    @(negedge clk);
    chk("ldurb_mem1_memread", MemRead, 1);
    chk("ldurb_mem1_regwrite", RegWrite, 0);
    chk("ldurb_mem1_alusrc", ALUSrc, 1);
    chk("ldurb_mem1_done", done, 0);
    @(negedge clk);
    chk("ldurb_mem2_memread", MemRead, 1);
    chk("ldurb_mem2_regwrite", RegWrite, 1);
    chk("ldurb_mem2_xferbyte", xferByte, 1);
    @(negedge clk);
    chk("ldurb_done", done, 1);
    chk("ldurb_done_memread", MemRead, 0);
    chk("ldurb_done_regwrite", RegWrite, 0);
    @(negedge clk);

    // Illegal word, then ADDI offered in the pulse cycle
    fetch_if.instr       = 32'h00000000;
    fetch_if.instr_valid = 1'b1;
    @(negedge clk);
    chk("ill_pulse", illegal, 1);
    chk("ill_ready", fetch_if.instr_ready, 1);
    chk("ill_regwrite", RegWrite, 0);
    chk("ill_memwrite", MemWrite, 0);
    chk("ill_memread", MemRead, 0);
    chk("ill_reg2loc", Reg2Loc, 0);
    chk("ill_done", done, 0);
    fetch_if.instr = 32'h910803E0;
    @(negedge clk);
    fetch_if.instr_valid = 1'b0;
    chk("ill_pulse_end", illegal, 0);
    chk("ill_next_chooseimm", ChooseImm, 1);
    chk("ill_next_ready", fetch_if.instr_ready, 0);
    @(negedge clk);
    chk("ill_next_done", done, 1);
    @(negedge clk);

    // STUR X1,[X2,#0] interrupted by reset during EXEC
    fetch_if.instr       = 32'hF8000041;
    fetch_if.instr_valid = 1'b1;
    @(negedge clk);
    fetch_if.instr_valid = 1'b0;
    chk("stur_memwrite", MemWrite, 1);
    chk("stur_reg2loc", Reg2Loc, 0);
    chk("stur_alusrc", ALUSrc, 1);
    reset = 1'b0;
    #1;
    chk("stur_rst_memwrite", MemWrite, 0);
    chk("stur_rst_ready", fetch_if.instr_ready, 1);
    chk("stur_rst_flags_q", flags_q, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stur_post_memwrite", MemWrite, 0);
      chk("stur_post_done", done, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Multi-cycle control sequencer for the single-issue 64-bit LEGv8 datapath. It accepts one 32-bit instruction at a time over a valid/ready handshake, decodes it, and drives the datapath's register-field and control inputs for the required number of cycles. It also latches ALU flags for flag-setting instructions. It sits between the fetch stage and `datapath`, replacing the hand-driven control bus used in datapath bring-up.

## Interface
Parameters:
- `LOAD_CYCLES`, default 2: cycles spent on LDUR/LDURB, in EXEC plus MEM (legal values 2–4).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  instruction offered.
- `instr`  in  32  LEGv8 instruction word.
- `instr_ready`  out  1  sequencer can accept an instruction.
- `flags`  in  4  {N,Z,C,V} from datapath ALU.
- `Rd`, `Rm`, `Rn`  out  5 each  register fields.
- `Daddr9`  out  9  load/store offset.
- `Imm12`  out  12  ADDI immediate.
- `Shamt`  out  2  MOVK/MOVZ hw field.
- `Imm16`  out  16  MOV immediate.
- `Reg2Loc`, `ALUSrc`, `MemToReg`, `RegWrite`, `MemWrite`, `MemRead`, `ChooseImm`, `xferByte`, `ChooseMovk`, `ChooseMovz`  out  1 each  datapath controls.
- `ALUOp`  out  3  ALU operation.
- `flags_q`  out  4  latched flags.
- `done`  out  1  one-cycle pulse: instruction retired.
- `illegal`  out  1  one-cycle pulse: undecodable instruction dropped.

## Operation
- FSM states: IDLE, EXEC, MEM, DONE.
- IDLE:
  - `instr_ready`=1.
  - On `instr_valid & instr_ready`, latch `instr`.
  - Legal opcode: go to EXEC. Illegal opcode: pulse `illegal` next cycle and stay IDLE.
- Decode (opcode bits [31:21], MOV [31:23]):
  - ADDI `1001000100`: ChooseImm=1, ALUSrc=1, ALUOp=010, RegWrite.
  - ADDS `10101011000`: ALUOp=010, RegWrite, sets flags.
  - SUBS `11101011000`: ALUOp=011, RegWrite, sets flags.
  - STUR `11111000000` / STURB `00111000000`: Reg2Loc=0, ALUSrc=1, ALUOp=010, MemWrite. xferByte=1 for the B variant.
  - LDUR `11111000010` / LDURB `00111000010`: ALUSrc=1, MemToReg=1, MemRead, ALUOp=010. xferByte=1 for the B variant.
  - MOVK `111100101`: ChooseMovk=1, ALUOp=000, RegWrite.
  - MOVZ `110100101`: ChooseMovz=1, ALUOp=000, RegWrite.
- Reg2Loc=1 for all non-store instructions.
- Field outputs are driven from the latched instruction: Rd[4:0], Rn[9:5], Rm[20:16], Daddr9[20:12], Imm12[21:10], Imm16[20:5], Shamt[22:21].
- EXEC: all decoded controls asserted for one cycle.
  - Non-load: go to DONE.
  - Load: go to MEM.
- MEM: MemRead, MemToReg, ALUSrc, ALUOp and xferByte are held.
  - RegWrite is asserted only in the final MEM cycle.
  - MEM lasts `LOAD_CYCLES`-1 cycles, counted by a 2-bit counter, then goes to DONE.
- DONE: `done`=1 and all controls 0. Go to IDLE.
- Outside EXEC and MEM, RegWrite, MemWrite and MemRead are always 0, and every other control is 0.

## Timing
- Reset (asynchronous, at any time, including mid-instruction):
  - State returns to IDLE and the counter clears.
  - All outputs go to 0, except `instr_ready`, which goes to 1.
  - `flags_q`=0.
  - An interrupted store or load is abandoned. No write is issued after reset deasserts.
- Latency from acceptance edge to `done` pulse:
  - Non-load: EXEC at cycle 1, `done` at cycle 2.
  - Load: `done` at cycle `LOAD_CYCLES`+1.
- Throughput: a new accept is possible the cycle after DONE. Back-to-back non-loads issue every 3 cycles.
- `instr` only needs to be stable in the accept cycle.
- `instr_valid` held high while `instr_ready`=0 has no effect.
- A flag-setting instruction updates `flags_q` at the end of its EXEC cycle, from `flags` sampled that cycle.
- The `illegal` pulse occurs in the cycle after acceptance. `instr_ready` stays 1.

## Configuration
- `DPSEQ_FLAGREG_EN`:
  - Defined: `flags_q` is a 4-bit register updated only by ADDS/SUBS, as described in Timing.
  - Undefined: no flag register is built, `flags_q` is tied to 4'b0000, and the `flags` input is ignored.

## Test plan
- Reset low mid-EXEC of STUR → MemWrite=0 immediately and `instr_ready`=1. After reset release, no MemWrite occurs for 5 cycles.
- ADDI X0,X31,#512 (0x910803E0) → next cycle: ChooseImm=1, ALUSrc=1, RegWrite=1, ALUOp=010, Rd=0, Rn=31, Imm12=512. `done` the cycle after.
- LDURB X9,[X31,#16] with `LOAD_CYCLES`=3 → MemRead high for 3 cycles, RegWrite only in the third, xferByte=1, Daddr9=16. `done` 4 cycles after accept.
- SUBS X5,X31,X30 with `flags`=4'b1000 in EXEC → `flags_q`=4'b1000 (macro defined). Same test without the macro → `flags_q`=0.
- MOVK X0,#0xFFFF,LSL 16 → ChooseMovk=1, Shamt=01, Imm16=FFFF, ALUOp=000, RegWrite=1 for exactly one cycle.
- Instruction 0x00000000 → `illegal` pulse, no control asserted, `instr_ready` stays 1. A valid ADDI presented next cycle is accepted.
